// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode seven-segment driver: one digit per enable tick,
// frame-coherent shadow register, leading-zero blanking and anode dead-time.
module seven_seg_scan #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned BLANK_CYCLES = 2,
    parameter bit          LEAD_BLANK   = 1'b1
) (
    input  logic                    clock,
    input  logic                    greset,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned FW = 5 * NUM_DIGITS;
    localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [IW-1:0]         idx_q, idx_d;
    logic [FW-1:0]         shadow_q, shadow_d;
    logic [FW-1:0]         disp_q, disp_d;
    logic [7:0]            blank_q, blank_d;
    logic                  active_q, active_d;
    logic                  frame_d;
    logic [NUM_DIGITS-1:0] an_d;
    logic [6:0]            seg_d;
    logic                  dp_d;

    always_comb begin
        idx_d    = idx_q;
        disp_d   = disp_q;
        active_d = active_q;
        frame_d  = 1'b0;
        blank_d  = (blank_q != 8'd0) ? blank_q - 8'd1 : 8'd0;
        shadow_d = load ? {dp_in, value} : shadow_q;
        if (enable) begin
            active_d = 1'b1;
            blank_d  = 8'(BLANK_CYCLES);
            if (idx_q == LAST) begin
                idx_d   = '0;
                // Commit the pre-load shadow so a same-edge load lands next frame.
                disp_d  = shadow_q;
                frame_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Outputs come from next-state so the pins move on the same edge as idx.
    always_comb begin
        logic       zero_run;
        logic [3:0] nib_sel;
        logic       dp_sel;
        logic       lz_sel;
        zero_run = 1'b1;
        nib_sel  = 4'h0;
        dp_sel   = 1'b0;
        lz_sel   = 1'b0;
        an_d     = '1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (disp_d[4*k +: 4] == 4'h0);
            if (idx_d == IW'(k)) begin
                nib_sel = disp_d[4*k +: 4];
                dp_sel  = disp_d[4*NUM_DIGITS + k];
                lz_sel  = zero_run && (k != 0);
                if (blank_d == 8'd0) begin
                    an_d[k] = 1'b0;
                end
            end
        end
        seg_d = (LEAD_BLANK && lz_sel) ? 7'h7F : decode(nib_sel);
        dp_d  = ~dp_sel;
        if (!active_d) begin
            an_d  = '1;
            seg_d = 7'h7F;
            dp_d  = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (greset) begin
            idx_q      <= '0;
            shadow_q   <= '0;
            disp_q     <= '0;
            blank_q    <= 8'd0;
            active_q   <= 1'b0;
            an         <= '1;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            disp_q     <= disp_d;
            blank_q    <= blank_d;
            active_q   <= active_d;
            an         <= an_d;
            seg        <= seg_d;
            dp         <= dp_d;
            frame_done <= frame_d;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan: three parameterisations share one stimulus stream.
module tb_seven_seg_scan;

    logic        clock = 1'b0;
    logic        greset, enable, load;
    logic [15:0] value;
    logic [3:0]  dp_in;

    logic [3:0] an0, an1, an2;
    logic [6:0] seg0, seg1, seg2;
    logic       dp0, dp1, dp2;
    logic       fd0, fd1, fd2;

    int vectors = 0;
    int errors  = 0;

    logic [3:0] exp_an   [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] seg_12af [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};

    always #5 clock = ~clock;

    seven_seg_scan #(.NUM_DIGITS(4), .BLANK_CYCLES(0), .LEAD_BLANK(1'b0)) u0 (
        .clock(clock), .greset(greset), .enable(enable), .value(value), .dp_in(dp_in),
        .load(load), .an(an0), .seg(seg0), .dp(dp0), .frame_done(fd0)
    );

    seven_seg_scan #(.NUM_DIGITS(4), .BLANK_CYCLES(0), .LEAD_BLANK(1'b1)) u1 (
        .clock(clock), .greset(greset), .enable(enable), .value(value), .dp_in(dp_in),
        .load(load), .an(an1), .seg(seg1), .dp(dp1), .frame_done(fd1)
    );

    seven_seg_scan #(.NUM_DIGITS(4), .BLANK_CYCLES(3), .LEAD_BLANK(1'b1)) u2 (
        .clock(clock), .greset(greset), .enable(enable), .value(value), .dp_in(dp_in),
        .load(load), .an(an2), .seg(seg2), .dp(dp2), .frame_done(fd2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic step();
        enable = 1'b1;
        tick();
        enable = 1'b0;
    endtask

    initial begin
        greset = 1'b1;
        enable = 1'b0;
        load   = 1'b0;
        value  = 16'h0;
        dp_in  = 4'h0;
        tick();
        tick();
        chk("rst_an", 32'(an0), 32'hF);
        chk("rst_seg", 32'(seg0), 32'h7F);
        chk("rst_dp", 32'(dp0), 32'h1);
        chk("rst_fd", 32'(fd0), 32'h0);
        chk("rst_an2", 32'(an2), 32'hF);
        greset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_an0", 32'(an0), 32'hF);
            chk("idle_an2", 32'(an2), 32'hF);
            chk("idle_seg0", 32'(seg0), 32'h7F);
            chk("idle_fd0", 32'(fd0), 32'h0);
        end

        // Scan order with 12AF.
        value = 16'h12AF;
        load  = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fill_fd", 32'(fd0), 32'h0);
        end
        step();
        chk("wrap_fd", 32'(fd0), 32'h1);
        chk("wrap_an", 32'(an0), 32'hE);
        chk("wrap_seg", 32'(seg0), 32'h0E);
        chk("wrap_dp", 32'(dp0), 32'h1);
        tick();
        chk("fd_width", 32'(fd0), 32'h0);
        chk("hold_an", 32'(an0), 32'hE);
        for (int i = 1; i < 4; i++) begin
            step();
            chk("scan_an", 32'(an0), 32'(exp_an[i]));
            chk("scan_seg", 32'(seg0), 32'(seg_12af[i]));
            chk("scan_fd", 32'(fd0), 32'h0);
        end
        step();
        chk("wrap2_fd", 32'(fd0), 32'h1);
        chk("wrap2_an", 32'(an0), 32'hE);

        // Frame coherency: mid-frame load waits for the wrap.
        value = 16'h1111;
        load  = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("coh_d0", 32'(seg0), 32'h79);
        step();
        step();
        chk("coh_d2a", 32'(seg0), 32'h79);
        value = 16'h2222;
        load  = 1'b1;
        tick();
        load = 1'b0;
        chk("coh_d2b", 32'(seg0), 32'h79);
        step();
        chk("coh_d3", 32'(seg0), 32'h79);
        step();
        chk("coh_new", 32'(seg0), 32'h24);
        chk("coh_an", 32'(an0), 32'hE);

        // Load on the wrap edge itself appears one frame later.
        for (int i = 0; i < 3; i++) step();
        value  = 16'h3333;
        load   = 1'b1;
        enable = 1'b1;
        tick();
        load   = 1'b0;
        enable = 1'b0;
        chk("wl_old", 32'(seg0), 32'h24);
        chk("wl_fd", 32'(fd0), 32'h1);
        for (int i = 0; i < 3; i++) step();
        chk("wl_old_d3", 32'(seg0), 32'h24);
        step();
        chk("wl_new", 32'(seg0), 32'h30);

        // Leading-zero blanking.
        value = 16'h0050;
        dp_in = 4'b1000;
        load  = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("lz_d0_seg", 32'(seg1), 32'h40);
        chk("lz_d0_dp", 32'(dp1), 32'h1);
        chk("lz_d0_an", 32'(an1), 32'hE);
        step();
        chk("lz_d1_seg", 32'(seg1), 32'h12);
        step();
        chk("lz_d2_seg", 32'(seg1), 32'h7F);
        chk("lz_d2_an", 32'(an1), 32'hB);
        chk("lz_d2_dp", 32'(dp1), 32'h1);
        chk("nolz_d2_seg", 32'(seg0), 32'h40);
        step();
        chk("lz_d3_seg", 32'(seg1), 32'h7F);
        chk("lz_d3_dp", 32'(dp1), 32'h0);
        chk("lz_d3_an", 32'(an1), 32'h7);

        value = 16'h0000;
        dp_in = 4'h0;
        load  = 1'b1;
        tick();
        load = 1'b0;
        step();
        chk("z_d0_seg", 32'(seg1), 32'h40);
        step();
        chk("z_d1_seg", 32'(seg1), 32'h7F);
        step();
        step();
        chk("z_d3_seg", 32'(seg1), 32'h7F);
        chk("z_d3_dp", 32'(dp1), 32'h1);

        // Anode dead-time on u2.
        step();
        chk("dt_e0_an", 32'(an2), 32'hF);
        chk("dt_e0_seg", 32'(seg2), 32'h40);
        tick();
        chk("dt_e1_an", 32'(an2), 32'hF);
        tick();
        chk("dt_e2_an", 32'(an2), 32'hF);
        tick();
        chk("dt_e3_an", 32'(an2), 32'hE);
        step();
        chk("dt_s1_an", 32'(an2), 32'hF);
        tick();
        chk("dt_s1b_an", 32'(an2), 32'hF);
        step();
        chk("dt_rs_an", 32'(an2), 32'hF);
        chk("dt_u0_an", 32'(an0), 32'hB);
        tick();
        chk("dt_rs1_an", 32'(an2), 32'hF);
        tick();
        chk("dt_rs2_an", 32'(an2), 32'hF);
        tick();
        chk("dt_rs3_an", 32'(an2), 32'hB);

        // Reset mid-frame at idx=2, then periodic enables every 5 clocks.
        greset = 1'b1;
        tick();
        greset = 1'b0;
        chk("mr_an", 32'(an0), 32'hF);
        chk("mr_seg", 32'(seg0), 32'h7F);
        chk("mr_dp", 32'(dp0), 32'h1);
        chk("mr_fd", 32'(fd0), 32'h0);
        chk("mr_an2", 32'(an2), 32'hF);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mr_idle_an", 32'(an0), 32'hF);
        end
        for (int j = 1; j < 4; j++) begin
            step();
            chk("per_an", 32'(an0), 32'(exp_an[j]));
            chk("per_seg", 32'(seg0), 32'h40);
            if (j == 1) chk("per_lz_seg", 32'(seg1), 32'h7F);
            for (int i = 0; i < 4; i++) begin
                tick();
                chk("per_hold_an", 32'(an0), 32'(exp_an[j]));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
- Time-multiplexed driver for an N-digit common-anode seven-segment display.
- Consumes the single-cycle `enable` tick from the upstream clock-enable generator and advances one digit per tick.
- Holds a coherent frame of hex nibbles and decimal points, applies optional leading-zero blanking and anode dead-time, and drives the board's active-low `an`/`seg`/`dp` pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal 2..8.
- BLANK_CYCLES, 2, clocks all anodes stay off after each digit step (ghosting suppression); legal 0..255.
- LEAD_BLANK, 1, 1 = suppress leading zeros (digit 0 is never suppressed); 0 = show every digit.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- greset  in  1  synchronous active-high reset.
- enable  in  1  scan tick from the clock-enable generator; one clock wide.
- value  in  4*NUM_DIGITS  hex nibbles; nibble k = value[4k+3:4k] is digit k, digit 0 is rightmost.
- dp_in  in  NUM_DIGITS  decimal point request per digit, active-high.
- load  in  1  capture value/dp_in into the shadow register this cycle.
- an  out  NUM_DIGITS  anode enables, active-low, one-hot-low or all ones.
- seg  out  7  segments, active-low; seg[0]=a … seg[6]=g.
- dp  out  1  decimal point, active-low.
- frame_done  out  1  one-cycle pulse when the scan wraps and a new frame is committed.

Behaviour:
- Reset (greset=1 at an edge): idx=0, shadow=0, disp=0, blank_cnt=0, an=all ones, seg=7'h7F, dp=1, frame_done=0. Outputs stay dark until the first enable.
- Shadow register: on any edge with load=1, shadow <= {dp_in, value}. The last load before a frame boundary wins.
- Step (edge with enable=1):
  - idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1.
  - If idx wraps: disp <= shadow; frame_done <= 1 for exactly that one cycle.
  - blank_cnt <= BLANK_CYCLES.
- Same-edge load and wrap: disp takes the pre-load shadow; the new load appears in the next frame.
- Outputs are registered and computed from next-state idx/disp/blank_cnt, so they change on the same edge as idx.
- Blanking window: while blank_cnt != 0, an = all ones and blank_cnt decrements each clock. Then an[idx]=0 and all other anode bits are 1.
- With BLANK_CYCLES=0, the anode switches on the step edge itself.
- seg and dp are always driven for the current idx, including during blanking.
- An enable arriving during a blanking window still steps the scan and reloads blank_cnt.
- Decode, active-low, nibble to seg:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E (hex)
- Leading-zero blanking (LEAD_BLANK=1): a digit k>0 is blanked (seg=7'h7F) if its nibble and every higher nibble in disp are 0. The anode is still driven. dp = ~dp_bit[k] regardless of blanking.
- enable held high for consecutive cycles steps once per cycle. No error handling; no latency beyond one clock from enable to pins.
- greset asserted mid-frame returns everything to reset state on that edge. The next enable drives digit 1 with disp=0, because idx advances 0->1 on that enable.

Test Plan:
- Reset/idle: greset 1 for 2 clocks, no enable for 20 clocks -> an=4'hF, seg=7'h7F, dp=1, frame_done=0 throughout.
- Scan order, BLANK_CYCLES=0, LEAD_BLANK=0: load value=16'h12AF, wait one frame (4 enables).
  - Next enables give an 4'hE/D/B/7 with seg 0E/08/24/79 (digits 0..3).
  - frame_done pulses once per 4 enables, on the wrap edge.
- Frame coherency: load 16'h1111, then mid-frame (idx=2) load 16'h2222.
  - Digits 2,3 still show 1 (seg 79) for the rest of the frame; all digits show 24 only after the wrap.
  - Load on the exact wrap edge -> the value appears one frame later.
- Leading zeros, LEAD_BLANK=1: value=16'h0050, dp_in=4'b1000.
  - Digit0 seg=40, digit1 seg=12, digit2 seg=7F, digit3 seg=7F with dp=0.
  - value=16'h0000 -> only digit0 shows 40.
- Dead time, BLANK_CYCLES=3: after each enable, an=all ones for exactly 3 clocks, then one low bit.
  - An enable 1 clock after the previous one restarts the 3-clock window and advances idx.
- Reset mid-frame plus upstream integration: instantiate with clkEnable_gen (DES_CLOCK small).
  - Assert greset at idx=2 -> next edge an=4'hF, idx=0.
  - Outputs resume only on the next enable tick, at period equal to the generator's enable spacing.
